// File: rtl/nec_ir_pkg.sv
// Purpose : shared state encoding and NEC unit lengths for the IR transmit path.
// Latency : n/a (types, constants and pure functions only).
// Backpressure: n/a.
package nec_ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } state_t;

    // Phase lengths in NEC units (one unit = 562.5 us nominal)
    localparam int LEAD_MARK_U  = 16;
    localparam int LEAD_SPACE_U = 8;
    localparam int REP_SPACE_U  = 4;
    localparam int BIT_MARK_U   = 1;
    localparam int ZERO_SPACE_U = 1;
    localparam int ONE_SPACE_U  = 3;
    localparam int STOP_U       = 1;

    // Emitter envelope is on only during the mark phases
    function automatic logic is_mark(input state_t s);
        return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

    // Unit counter counts down to zero, so a phase of n units loads n-1
    function automatic logic [7:0] unit_load(input int units);
        return 8'(units - 1);
    endfunction

endpackage

// File: rtl/nec_unit_tick.sv
// Purpose : prescaler that emits a one-cycle unit strobe every TICK_DIV clocks.
// Latency : strobe on the TICK_DIV-th cycle after a restart (restart at edge N -> strobe in cycle N+TICK_DIV-1).
// Backpressure: none; free-running, restart is a synchronous clear.
// Ports: clk, reset (async active-low), restart (sync clear), tick (unit strobe).
module nec_unit_tick #(
    parameter int TICK_DIV = 28125
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int             W    = $clog2(TICK_DIV);
    localparam logic [W-1:0]   LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Decoded straight from the counter register, so no extra pipeline stage
    assign tick = (cnt == LAST);

endmodule

// File: rtl/nec_ir_tx.sv
// Purpose : NEC IR transmitter - leader, 32 data bits (MSB first) or repeat, stop burst, guard gap.
// Latency : request accepted at edge N -> busy at N, ir_out mark from edge N+1; done pulses as busy drops.
// Backpressure: start/rep honoured only while idle; requests during busy are dropped, never queued.
// Ports: clk, reset (async active-low), start/rep (one-cycle requests), data[31:0] (frame word),
//        ir_out (emitter drive), busy (frame or gap active), done (end-of-gap pulse).
// Build option: define IR_TX_CARRIER_EN to gate ir_out with an internal carrier of CARRIER_DIV half-period.
module nec_ir_tx
    import nec_ir_pkg::*;
#(
    parameter int TICK_DIV    = 28125,
    parameter int GAP_UNITS   = 72,
    parameter int CARRIER_DIV = 658
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rep,
    input  logic [31:0] data,
    output logic        ir_out,
    output logic        busy,
    output logic        done
);

    // Reject configurations the counters cannot represent
    if (TICK_DIV < 2 || GAP_UNITS < 1 || GAP_UNITS > 256 || CARRIER_DIV < 1) begin : g_cfg_err
        $error("nec_ir_tx: illegal parameter set");
    end

    state_t      state;
    logic [7:0]  ucnt;
    logic [4:0]  bit_cnt;
    logic [31:0] sreg;
    logic        is_rep;
    logic        env_q;
    logic        accept;
    logic        unit_tick;

    assign accept = (state == IDLE) && (start || rep);

    // Restarting the prescaler on acceptance makes the first unit a full TICK_DIV
    nec_unit_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (accept),
        .tick    (unit_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ucnt    <= '0;
            bit_cnt <= '0;
            sreg    <= '0;
            is_rep  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            env_q   <= 1'b0;
        end else begin
            done  <= 1'b0;
            // Envelope trails the state by one cycle: mark starts the edge after acceptance
            env_q <= is_mark(state);
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= LEAD_MARK;
                        ucnt   <= unit_load(LEAD_MARK_U);
                        busy   <= 1'b1;
                        // A simultaneous start and rep sends the full frame
                        is_rep <= !start;
                        if (start) begin
                            sreg <= data;
                        end
                    end
                end
                default: begin
                    if (unit_tick) begin
                        if (ucnt != 8'd0) begin
                            ucnt <= ucnt - 8'd1;
                        end else begin
                            case (state)
                                LEAD_MARK: begin
                                    state <= LEAD_SPACE;
                                    ucnt  <= unit_load(is_rep ? REP_SPACE_U : LEAD_SPACE_U);
                                end
                                LEAD_SPACE: begin
                                    bit_cnt <= '0;
                                    state   <= is_rep ? STOP_MARK : BIT_MARK;
                                    ucnt    <= unit_load(is_rep ? STOP_U : BIT_MARK_U);
                                end
                                BIT_MARK: begin
                                    state <= BIT_SPACE;
                                    ucnt  <= unit_load(sreg[31] ? ONE_SPACE_U : ZERO_SPACE_U);
                                end
                                BIT_SPACE: begin
                                    sreg    <= {sreg[30:0], 1'b0};
                                    bit_cnt <= bit_cnt + 5'd1;
                                    if (bit_cnt == 5'd31) begin
                                        state <= STOP_MARK;
                                        ucnt  <= unit_load(STOP_U);
                                    end else begin
                                        state <= BIT_MARK;
                                        ucnt  <= unit_load(BIT_MARK_U);
                                    end
                                end
                                STOP_MARK: begin
                                    state <= GAP;
                                    ucnt  <= unit_load(GAP_UNITS);
                                end
                                GAP: begin
                                    // Idle again next cycle, so a new request there is accepted
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                                default: begin
                                    state <= IDLE;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

`ifdef IR_TX_CARRIER_EN
    localparam int           CW     = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CARRIER_DIV - 1);

    logic [CW-1:0] ccnt;
    logic          car_q;

    // Carrier phase is re-armed high on the first cycle of every mark so each
    // burst starts identically regardless of the previous burst's phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ccnt  <= '0;
            car_q <= 1'b0;
        end else if (is_mark(state) && !env_q) begin
            ccnt  <= '0;
            car_q <= 1'b1;
        end else if (ccnt == C_LAST) begin
            ccnt  <= '0;
            car_q <= ~car_q;
        end else begin
            ccnt  <= ccnt + 1'b1;
        end
    end

    assign ir_out = env_q & car_q;
`else
    assign ir_out = env_q;
`endif

endmodule

// File: tb/tb_nec_ir_tx.sv
// Purpose : self-checking bench for nec_ir_tx against a waveform model built from NEC unit rules.
// Latency : checks every cycle of each frame relative to the acceptance edge.
// Backpressure: exercises dropped requests during busy and back-to-back acceptance in the done cycle.
module tb_nec_ir_tx;

    localparam int T  = 4;
    localparam int G  = 2;
    localparam int CD = 1;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        rep   = 1'b0;
    logic [31:0] data  = '0;
    logic        ir_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    bit wave[$];

    nec_ir_tx #(
        .TICK_DIV    (T),
        .GAP_UNITS   (G),
        .CARRIER_DIV (CD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .rep    (rep),
        .data   (data),
        .ir_out (ir_out),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Append one phase of u units at emitter level lvl, cycle by cycle
    task automatic add_seg(input bit lvl, input int u);
        for (int c = 0; c < u * T; c++) begin
`ifdef IR_TX_CARRIER_EN
            wave.push_back(lvl && (((c / CD) % 2) == 0));
`else
            wave.push_back(lvl);
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle ir", ir_out, 0);
            chk("idle busy", busy, 0);
            chk("idle done", done, 0);
        end
    endtask

    // Drive a request at the current negedge and check every cycle up to the done cycle.
    // Returns sitting at the done-cycle negedge so a following send is back-to-back.
    task automatic send(input logic [31:0] d, input bit do_start, input bit do_rep,
                        input bit disturb, input int abort_at, input string tag);
        int units;
        int b;
        bit exp_ir;
        wave.delete();
        add_seg(1'b1, 16);
        if (do_start) begin
            add_seg(1'b0, 8);
            for (int i = 31; i >= 0; i--) begin
                add_seg(1'b1, 1);
                add_seg(1'b0, d[i] ? 3 : 1);
            end
            units = 16 + 8 + 32 + (32 + 2 * $countones(d)) + 1;
        end else begin
            add_seg(1'b0, 4);
            units = 21;
        end
        add_seg(1'b1, 1);
        b = T * (units + G);

        data  = d;
        start = do_start;
        rep   = do_rep;
        @(negedge clk);
        start = 1'b0;
        rep   = 1'b0;
        for (int k = 0; k <= b; k++) begin
            exp_ir = (k >= 1 && (k - 1) < wave.size()) ? wave[k-1] : 1'b0;
            chk($sformatf("%s ir k=%0d", tag, k), ir_out, exp_ir);
            chk($sformatf("%s busy k=%0d", tag, k), busy, (k < b));
            chk($sformatf("%s done k=%0d", tag, k), done, (k == b));
            if (k == abort_at) begin
                #2 reset = 1'b0;
                #1;
                chk($sformatf("%s abort ir", tag), ir_out, 0);
                chk($sformatf("%s abort busy", tag), busy, 0);
                chk($sformatf("%s abort done", tag), done, 0);
                @(negedge clk);
                chk($sformatf("%s held ir", tag), ir_out, 0);
                chk($sformatf("%s held busy", tag), busy, 0);
                reset = 1'b1;
                return;
            end
            start = 1'b0;
            rep   = 1'b0;
            if (k == b) break;
            if (disturb) begin
                if (k == 0) data = 32'hFFFF_FFFF;
                else if ($urandom_range(0, 9) == 0) data = $urandom;
                if ($urandom_range(0, 19) == 0) start = 1'b1;
                if ($urandom_range(0, 19) == 0) rep = 1'b1;
                if (k == b - 1) rep = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int mode;
        logic [31:0] rd;
        repeat (2) @(negedge clk);
        chk("rst ir", ir_out, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        reset = 1'b1;
        idle(1);

        send(32'h00FF_A25D, 1'b1, 1'b0, 1'b0, -1, "full");
        send(32'h0000_0000, 1'b0, 1'b1, 1'b0, -1, "rep");
        idle(2);
        send(32'h00FF_A25D, 1'b1, 1'b0, 1'b1, -1, "ignore");
        idle(1);
        send(32'h00FF_A25D, 1'b1, 1'b1, 1'b0, -1, "both");
        idle(1);
        send(32'h00FF_A25D, 1'b1, 1'b0, 1'b0, 201, "abort");
        send(32'h00FF_A25D, 1'b1, 1'b0, 1'b0, -1, "after_rst");

        for (int n = 0; n < 8; n++) begin
            mode = $urandom_range(0, 2);
            rd   = $urandom;
            send(rd, (mode != 1), (mode != 0), ($urandom_range(0, 1) == 1), -1,
                 $sformatf("rnd%0d", n));
            idle($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nec_ir_tx.md
Name: nec_ir_tx

Overview:
NEC-protocol infrared transmitter, the send-side counterpart of the IR decode path.
- Accepts a 32-bit frame word or a repeat request on a start handshake.
- Serialises it as NEC mark/space timing (leader, 32 bits, stop burst), followed by an inter-frame guard gap.
- Drives the IR LED driver pin; sits beside the board clock divider and is controlled by user logic (buttons or test sequencer).

Parameters:
TICK_DIV, 28125, clk cycles per NEC unit (562.5 us at 50 MHz); must be >= 2
GAP_UNITS, 72, guard units after stop burst before busy drops (~40.5 ms)
CARRIER_DIV, 658, clk cycles per carrier half-period (~38 kHz at 50 MHz); used only with carrier feature

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to send a full frame from data
rep  input  1  one-cycle request to send a repeat frame
data  input  32  frame word; sampled on accepted start; sent bit 31 first, bit 0 last
ir_out  output  1  IR drive; 1 = emitter on
busy  output  1  frame or guard gap in progress
done  output  1  one-cycle pulse at end of guard gap

Behaviour:
- Reset (reset=0, async): state IDLE; ir_out=0, busy=0, done=0; shift register, unit counter and prescaler cleared. Reset mid-frame aborts immediately, with ir_out forced 0 asynchronously.
- Request acceptance:
  - Accepted only in IDLE; start/rep while busy=1 are ignored, with no queueing.
  - start and rep in the same cycle: full frame wins.
  - Accepted at edge N: busy=1, state enters LEAD_MARK, and ir_out mark begins at edge N+1. The prescaler restarts at acceptance, so every unit is exactly TICK_DIV cycles.
- Unit lengths (in NEC units):
  - LEAD_MARK: 16.
  - LEAD_SPACE: 8 for a full frame, 4 for a repeat.
  - BIT_MARK: 1.
  - BIT_SPACE: 1 for a 0 bit, 3 for a 1 bit.
  - STOP_MARK: 1.
  - GAP: GAP_UNITS.
- State sequence:
  - Full frame: IDLE -> LEAD_MARK -> LEAD_SPACE -> (BIT_MARK -> BIT_SPACE) x32 -> STOP_MARK -> GAP -> IDLE.
  - Repeat: IDLE -> LEAD_MARK -> LEAD_SPACE(4) -> STOP_MARK -> GAP -> IDLE.
- Bit handling: a 5-bit bit counter counts 0..31. The shift register shifts left after each BIT_SPACE, and bit 31 selects the space length. data changes after acceptance have no effect.
- Output envelope: envelope = 1 in *_MARK states, 0 otherwise.
- busy falls on the last cycle of GAP and done=1 on that same cycle, so a new start on the next cycle is accepted.
- Total busy duration equals TICK_DIV x (units in frame + GAP_UNITS) cycles exactly.
  - Full frame units = 16 + 8 + 32 + (32 + 2 x popcount(data)) + 1.
  - Repeat frame units = 21.
- Counter widths: unit counter 8 bits; prescaler ceil(log2(TICK_DIV)) bits, counting 0..TICK_DIV-1 with wrap.

Optional Feature:
Macro IR_TX_CARRIER_EN.
- Defined: ir_out = envelope AND carrier. The carrier toggles every CARRIER_DIV cycles and is restarted high at the first cycle of each mark; ir_out is 0 in spaces and IDLE.
- Undefined: ir_out = envelope (unmodulated, for external modulator or loopback into the decoder); CARRIER_DIV is unused and no carrier logic is synthesised.

Decomposition:
- Package nec_ir_pkg holds:
  - state enum (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP);
  - unit constants LEAD_MARK_U=16, LEAD_SPACE_U=8, REP_SPACE_U=4, BIT_MARK_U=1, ZERO_SPACE_U=1, ONE_SPACE_U=3, STOP_U=1.
- One sub-module, nec_unit_tick: prescaler with a synchronous restart input, emitting a one-cycle unit strobe every TICK_DIV cycles.

Test Plan:
All scenarios use TICK_DIV=4, GAP_UNITS=2, CARRIER_DIV=1; the macro is undefined unless stated.
1. Full frame, data=32'h00FF_A25D:
   - ir_out high 64 cycles, then low 32.
   - 32 bits of 4-high/4-or-12-low, MSB first; first 8 bits are all 0, next 8 all 1.
   - Stop mark of 4 cycles; busy high exactly 492 cycles; done pulses once as busy falls.
2. rep pulse: mark 64, space 16, mark 4, gap 8; busy exactly 92 cycles; done once.
3. start during a frame, and rep during GAP: both ignored (waveform identical to scenario 1). start and rep together in IDLE: full-frame timing (492 cycles).
4. data changed to 32'hFFFF_FFFF one cycle after start: waveform still matches 32'h00FF_A25D.
5. reset pulled low mid-bit at cycle 200:
   - ir_out=0 and busy=0 immediately.
   - After release, start sends a clean frame from the leader.
6. IR_TX_CARRIER_EN defined:
   - ir_out toggles every cycle, starting at 1, during each mark.
   - ir_out is 0 throughout spaces and gap; envelope timing is as in scenario 1.
